// File: rtl/xps2_rx_fifo.sv
// PS/2 keyboard receiver: deserialises 11-bit frames, checks start/parity/stop and queues
// good scan codes in a FIFO behind a small register window (DATA, STATUS, CTRL).
module xps2_rx_fifo #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned FIFO_AW     = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              PS2_CLK,
  input  logic              PS2_DATA,
  output logic              irq
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
  logic                   r_clk_prev;
  state_e                 r_state;
  logic [2:0]             r_bitcnt;
  logic [7:0]             r_shift;
  logic                   r_par;
  logic [TmoW-1:0]        r_tmo;
  logic [7:0]             r_mem [Depth];
  logic [FIFO_AW-1:0]     r_wptr, r_rptr;
  logic [FIFO_AW:0]       r_count;
  logic                   r_ovf, r_perr, r_ferr;
  logic                   r_en, r_irq_en;

  logic w_ps2_clk, w_ps2_dat, w_fall;
  logic w_rd_data, w_wr_stat, w_wr_ctrl, w_flush;
  logic w_stop, w_par_ok, w_push, w_set_perr, w_set_ferr, w_tmo_hit;
  logic w_empty, w_full, w_pop, w_do_push, w_set_ovf;
  logic w_unused;

  assign w_unused = ^data_in[DATA_W-1:5];

  // Pins idle high, so the synchroniser resets to ones to avoid a false edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], PS2_CLK};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], PS2_DATA};
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign w_ps2_clk = r_clk_sync[SYNC_STAGES-1];
  assign w_ps2_dat = r_dat_sync[SYNC_STAGES-1];
  assign w_fall    = r_clk_prev & ~w_ps2_clk;

  assign w_rd_data = sel & ~we & (addr == 2'd0);
  assign w_wr_stat = sel & we & (addr == 2'd1);
  assign w_wr_ctrl = sel & we & (addr == 2'd2);
  assign w_flush   = w_wr_ctrl & data_in[2];

  assign w_stop     = r_en & w_fall & (r_state == StStop);
  assign w_par_ok   = ^{r_shift, r_par};
  assign w_push     = w_stop & w_ps2_dat & w_par_ok;
  assign w_set_perr = w_stop & w_ps2_dat & ~w_par_ok;
  assign w_tmo_hit  = r_en & ~w_fall & (r_state != StIdle) & (r_tmo == TmoW'(TIMEOUT_CYC));
  assign w_set_ferr = (w_stop & ~w_ps2_dat) | w_tmo_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_tmo    <= '0;
    end else if (!r_en) begin
      r_state <= StIdle;
      r_tmo   <= '0;
    end else if (w_fall) begin
      r_tmo <= '0;
      unique case (r_state)
        StIdle: begin
          if (!w_ps2_dat) begin
            r_state  <= StData;
            r_bitcnt <= '0;
          end
        end
        StData: begin
          r_shift  <= {w_ps2_dat, r_shift[7:1]};
          r_bitcnt <= r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) r_state <= StParity;
        end
        StParity: begin
          r_par   <= w_ps2_dat;
          r_state <= StStop;
        end
        StStop:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end else if (w_tmo_hit) begin
      r_state <= StIdle;
      r_tmo   <= '0;
    end else if (r_state != StIdle) begin
      r_tmo <= r_tmo + TmoW'(1);
    end
  end

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (FIFO_AW + 1)'(Depth));
  assign w_pop     = w_rd_data & ~w_empty;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign w_do_push = w_push & (~w_full | w_pop) & ~w_flush;
  assign w_set_ovf = w_push & w_full & ~w_pop & ~w_flush;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + FIFO_AW'(1);
      if (w_pop)     r_rptr <= r_rptr + FIFO_AW'(1);
      if (w_do_push && !w_pop)      r_count <= r_count + (FIFO_AW + 1)'(1);
      else if (!w_do_push && w_pop) r_count <= r_count - (FIFO_AW + 1)'(1);
    end
  end

  // Sticky flags: a set in the same cycle as a W1C wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf    <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_en     <= 1'b1;
      r_irq_en <= 1'b0;
    end else begin
      r_ovf  <= (r_ovf  & ~(w_wr_stat & data_in[2])) | w_set_ovf;
      r_perr <= (r_perr & ~(w_wr_stat & data_in[3])) | w_set_perr;
      r_ferr <= (r_ferr & ~(w_wr_stat & data_in[4])) | w_set_ferr;
      if (w_wr_ctrl) begin
        r_en     <= data_in[0];
        r_irq_en <= data_in[1];
      end
    end
  end

  always_comb begin
    data_out = '0;
    case (addr)
      2'd0: if (!w_empty) data_out[7:0] = r_mem[r_rptr];
      2'd1: begin
        data_out[0]               = ~w_empty;
        data_out[1]               = w_full;
        data_out[2]               = r_ovf;
        data_out[3]               = r_perr;
        data_out[4]               = r_ferr;
        data_out[8 +: FIFO_AW+1] = r_count;
      end
      2'd2: data_out[1:0] = {r_irq_en, r_en};
      default: data_out = '0;
    endcase
  end

  assign irq = ~w_empty & r_irq_en;

endmodule

// File: tb/tb_xps2_rx_fifo.sv
// Bench for xps2_rx_fifo: frame-level PS/2 driver, queue-based register model checked every
// cycle, plus literal register expectations for the directed scenarios.
module tb_xps2_rx_fifo;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int SS    = 2;
  localparam int TMO   = 300;
  localparam int DEPTH = 8;
  localparam int H     = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          sel, we;
  logic [1:0]    addr;
  logic [DW-1:0] data_in, data_out;
  logic          PS2_CLK, PS2_DATA;
  logic          irq;

  xps2_rx_fifo #(
    .DATA_W     (DW),
    .FIFO_AW    (AW),
    .SYNC_STAGES(SS),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .we      (we),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .PS2_CLK (PS2_CLK),
    .PS2_DATA(PS2_DATA),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [7:0] mq[$];
  logic       m_ovf, m_perr, m_ferr, m_en, m_irq_en;
  int         cyc = 0;
  int         ev_at = -1;
  int         ev_kind;
  logic [7:0] ev_byte;
  bit         mask_ferr = 0;
  bit         m_pop, m_flush, m_wstat, m_wctrl, s_ovf, s_perr, s_ferr, m_push;
  logic [31:0] m_msk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      2'd0: if (mq.size() != 0) v[7:0] = mq[0];
      2'd1: begin
        v[0]    = (mq.size() != 0);
        v[1]    = (mq.size() == DEPTH);
        v[2]    = m_ovf;
        v[3]    = m_perr;
        v[4]    = m_ferr;
        v[11:8] = 4'(mq.size());
      end
      2'd2: v[1:0] = {m_irq_en, m_en};
      default: v = '0;
    endcase
    return v;
  endfunction

  // Model update on each rising edge, comparison just after it.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst) begin
      mq.delete();
      {m_ovf, m_perr, m_ferr, m_irq_en} = '0;
      m_en = 1'b1;
    end else begin
      m_pop   = sel && !we && addr == 2'd0 && mq.size() != 0;
      m_wstat = sel && we && addr == 2'd1;
      m_wctrl = sel && we && addr == 2'd2;
      m_flush = m_wctrl && data_in[2];
      {s_ovf, s_perr, s_ferr, m_push} = '0;
      if (cyc == ev_at) begin
        if (ev_kind == 0) m_push = 1;
        else if (ev_kind == 1) s_perr = 1;
        else if (ev_kind == 2) s_ferr = 1;
      end
      if (m_wstat) begin
        if (data_in[2]) m_ovf = 0;
        if (data_in[3]) m_perr = 0;
        if (data_in[4]) m_ferr = 0;
      end
      if (m_wctrl) begin
        m_en     = data_in[0];
        m_irq_en = data_in[1];
      end
      if (m_flush) mq.delete();
      else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          if (mq.size() < DEPTH) mq.push_back(ev_byte);
          else s_ovf = 1;
        end
      end
      m_ovf  = m_ovf | s_ovf;
      m_perr = m_perr | s_perr;
      m_ferr = m_ferr | s_ferr;
    end
    #1;
    // Timeout instant is not modelled cycle-exactly; its flag is masked while pending.
    m_msk = (mask_ferr && addr == 2'd1) ? ~32'h10 : 32'hffff_ffff;
    chk("data_out", data_out & m_msk, exp_rd(addr) & m_msk);
    chk("irq", {31'b0, irq}, {31'b0, (mq.size() != 0) && m_irq_en});
  end

  // One PS/2 bit; called at a falling clk edge. Optional DATA read lands on the push edge.
  task automatic ps2_bit(input logic d, input bit is_stop, input bit pop_at);
    PS2_DATA = d;
    repeat (H) @(negedge clk);
    PS2_CLK = 1'b0;
    if (is_stop) ev_at = cyc + SS + 1;
    for (int i = 0; i < H; i++) begin
      @(negedge clk);
      if (pop_at && i == 1) begin
        sel = 1; we = 0; addr = 2'd0;
      end
      if (pop_at && i == 2) sel = 0;
    end
    PS2_CLK = 1'b1;
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop, 3 ignored by receiver
  task automatic send_frame(input logic [7:0] b, input int kind, input bit pop_at);
    logic p;
    p = ~^b;
    if (kind == 1) p = ~p;
    ps2_bit(1'b0, 0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 0, 0);
    ps2_bit(p, 0, 0);
    ev_kind = kind;
    ev_byte = b;
    ps2_bit((kind == 2) ? 1'b0 : 1'b1, kind != 3, pop_at);
    PS2_DATA = 1'b1;
  endtask

  task automatic bus_rd_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    sel = 1; we = 0; addr = a;
    #1 chk(name, data_out, exp);
    @(negedge clk);
    sel = 0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1; we = 1; addr = a; data_in = d;
    @(negedge clk);
    sel = 0; we = 0;
  endtask

  bit done;
  int rb, rf, pr;

  initial begin
    rst = 0; sel = 0; we = 0; addr = 0; data_in = 0;
    PS2_CLK = 1; PS2_DATA = 1;
    repeat (3) @(negedge clk);
    #1 chk("reset_status", data_out, 32'h0);
    rst = 1;
    bus_rd_chk(2'd2, 32'h1, "reset_ctrl");

    // Single good frame with irq enabled.
    bus_wr(2'd2, 32'h3);
    send_frame(8'h1C, 0, 0);
    repeat (5) @(negedge clk);
    #1 chk("irq_on", {31'b0, irq}, 32'h1);
    bus_rd_chk(2'd1, 32'h101, "t1_status");
    bus_rd_chk(2'd0, 32'h1C, "t1_data");
    bus_rd_chk(2'd1, 32'h000, "t1_status_empty");

    // Parity error and W1C.
    send_frame(8'h5A, 1, 0);
    repeat (5) @(negedge clk);
    bus_rd_chk(2'd1, 32'h008, "t2_perr");
    bus_wr(2'd1, 32'h08);
    bus_rd_chk(2'd1, 32'h000, "t2_perr_clr");

    // Overflow.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0);
    repeat (5) @(negedge clk);
    bus_rd_chk(2'd1, 32'h807, "t3_full_ovf");
    for (int i = 1; i <= 8; i++) bus_rd_chk(2'd0, 32'(i), $sformatf("t3_read%0d", i));
    bus_rd_chk(2'd1, 32'h004, "t3_ovf_sticky");
    bus_wr(2'd1, 32'h1C);

    // Push into a full FIFO together with a pop.
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 0, 0);
    send_frame(8'h33, 0, 1);
    repeat (5) @(negedge clk);
    bus_rd_chk(2'd1, 32'h803, "t5_status");
    for (int i = 2; i <= 8; i++) bus_rd_chk(2'd0, 32'(i), $sformatf("t5_read%0d", i));
    bus_rd_chk(2'd0, 32'h33, "t5_last");

    // Timeout of a stalled frame.
    mask_ferr = 1;
    for (int i = 0; i < 5; i++) ps2_bit(1'b0, 0, 0);
    PS2_DATA = 1'b1;
    repeat (TMO + 100) @(negedge clk);
    ev_kind = 2;
    ev_at = cyc + 1;
    repeat (2) @(negedge clk);
    mask_ferr = 0;
    bus_rd_chk(2'd1, 32'h010, "t4_ferr");
    bus_wr(2'd1, 32'h10);
    send_frame(8'h29, 0, 0);
    repeat (5) @(negedge clk);
    bus_rd_chk(2'd0, 32'h29, "t4_after");

    // Disable mid-frame discards it.
    for (int i = 0; i < 3; i++) ps2_bit(1'b0, 0, 0);
    bus_wr(2'd2, 32'h0);
    bus_rd_chk(2'd2, 32'h0, "dis_ctrl");
    for (int i = 0; i < 8; i++) ps2_bit(1'b1, 0, 0);
    PS2_DATA = 1'b1;
    bus_wr(2'd2, 32'h1);
    send_frame(8'h77, 0, 0);
    repeat (5) @(negedge clk);
    bus_rd_chk(2'd1, 32'h101, "dis_status");
    bus_rd_chk(2'd0, 32'h77, "dis_data");

    // Reset mid-frame, then flush.
    bus_wr(2'd2, 32'h3);
    send_frame(8'h11, 0, 0);
    send_frame(8'h12, 0, 0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b0, 0, 0);
    PS2_DATA = 1'b1;
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    bus_rd_chk(2'd1, 32'h0, "t6_rst_status");
    bus_rd_chk(2'd2, 32'h1, "t6_rst_ctrl");
    #1 chk("t6_rst_irq", {31'b0, irq}, 32'h0);
    send_frame(8'h45, 0, 0);
    send_frame(8'h46, 0, 0);
    repeat (5) @(negedge clk);
    bus_rd_chk(2'd1, 32'h201, "t6_two");
    bus_wr(2'd2, 32'h5);
    bus_rd_chk(2'd1, 32'h0, "t6_flush");

    // Random frames against random bus traffic.
    done = 0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 20)) @(negedge clk);
          rf = $urandom_range(0, 99);
          send_frame(8'($urandom), (rf < 70) ? 0 : (rf < 85) ? 1 : 2, 0);
        end
        repeat (6) @(negedge clk);
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          sel = 0; we = 0;
          pr = ((cyc / 400) % 2 == 1) ? 8 : 0;
          rb = $urandom_range(0, 99);
          data_in = $urandom;
          if (rb < pr) begin
            sel = 1; addr = 2'd0;
          end else if (rb < pr + 10) begin
            sel = 1; addr = 2'($urandom_range(1, 3));
          end else if (rb < pr + 14) begin
            sel = 1; we = 1; addr = 2'd1;
          end else if (rb < pr + 16) begin
            sel = 1; we = 1; addr = 2'd2;
            data_in[0] = 1'b1;
            data_in[2] = ($urandom_range(0, 3) == 0);
          end else begin
            addr = 2'($urandom_range(0, 3));
          end
        end
        sel = 0; we = 0;
      end
    join
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
